acc_cpu_core: RTL and testbench
===============================

# acc_cpu_core

Parametrised multi-cycle accumulator CPU core. It is the next generation of the fixed 16-bit/8-bit MAR/MBR/ACC/PC/IR/BR datapath. Data and address widths are generic, and memory access uses a req/ack handshake with arbitrary wait states instead of fixed single-cycle transfers. It also adds flag-driven conditional branching, an explicit halt state and illegal-opcode detection. It sits between the system memory (or memory arbiter) and the debug/status logic at SoC top.

## Interface
Parameters:
- DATA_W, 16, data word and instruction width; must be ≥ ADDR_W+4.
- ADDR_W, 8, address width; instruction operand field width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  output  ADDR_W  transaction address (MAR).
- mem_wdata  output  DATA_W  write data (MBR); valid while mem_req&mem_we.
- mem_rdata  input  DATA_W  read data; sampled on the cycle mem_req&mem_ack.
- mem_ack  input  1  transaction completes on any cycle with mem_req&mem_ack; may be asserted in the same cycle as mem_req.
- acc_out  output  DATA_W  accumulator value.
- pc_out  output  ADDR_W  program counter.
- flags  output  4  {ZF, CF, OF, SF}.
- halted  output  1  core is in HALT.
- illegal  output  1  sticky; set when an undefined opcode is decoded.

## Operation
Instruction format:
- Opcode is instr[DATA_W-1:ADDR_W]; only the low 4 bits are decoded, and the upper opcode bits must be 0 or the opcode is illegal.
- Operand address is instr[ADDR_W-1:0].

Opcodes:
- 0 NOP
- 1 LOAD: ACC←M[a]
- 2 STORE: M[a]←ACC
- 3 ADD
- 4 SUB
- 5 MPY
- 6 AND
- 7 OR
- 8 NOT: ACC←~M[a]
- 9 SHL
- A SHR: logical shift by M[a][$clog2(DATA_W)-1:0]
- B JMP: PC←a
- C JGEZ: PC←a if ACC[DATA_W-1]==0
- D JZ: PC←a if ZF
- F HALT
- E is illegal.

States:
- FETCH: mem_req=1, we=0, addr=PC. On ack: IR←rdata, PC←PC+1 (wraps 2^ADDR_W-1→0); go to DECODE.
- DECODE:
  - NOP/JMP/JGEZ/JZ: PC updated here; go to FETCH.
  - STORE: go to WRITE.
  - HALT: go to HALT.
  - Illegal opcode: set illegal; go to HALT.
  - All others: go to OPERAND.
- OPERAND: read M[a]. On ack: BR←rdata; go to EXECUTE.
- EXECUTE: ACC←ALU(ACC,BR) and flags updated; go to FETCH.
- WRITE: mem_req=1, we=1, wdata=ACC. On ack: go to FETCH.
- HALT: terminal; mem_req=0. Exited only by rst.

Arithmetic and flags:
- ADD/SUB wrap modulo 2^DATA_W. CF = carry-out (ADD) or borrow (SUB). OF = two's-complement overflow.
- MPY: ACC ← low DATA_W bits of the unsigned product; CF = OF = (high half ≠ 0).
- LOAD, logic and shift ops clear CF and OF.
- ZF and SF are computed from the new ACC value by every op that writes ACC.
- NOP, STORE, jumps and HALT leave flags unchanged.

Handshake rules:
- mem_addr, mem_we and mem_wdata are held stable from mem_req rise until ack.
- mem_req is never dropped before ack, except by rst.
- mem_ack while mem_req=0 is ignored.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, ACC=0, IR=0, BR=0, flags=0, illegal=0, halted=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- First mem_req is asserted in the first cycle after rst deasserts.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU/LOAD instructions: 4 cycles.
  - STORE: 3 cycles.
  - NOP/jumps: 2 cycles.
  - HALT: 2 cycles to halted=1.
- Each wait cycle (req without ack) stretches only the current FETCH/OPERAND/WRITE state.
- rst asserted mid-transaction returns the core to reset values immediately; mem_req falls asynchronously and the abandoned transaction is discarded.
- PC increment and a taken jump never occur in the same cycle (different states).
- PC wrap-around is silent.

## Structure
- Package acc_cpu_pkg holds:
  - opcode localparams
  - state enum (FETCH, DECODE, OPERAND, EXECUTE, WRITE, HALT)
  - flag bit indices
- Sub-module acc_cpu_alu: combinational, parametrised by DATA_W; inputs op, acc, br; outputs result and 4 flags.
- The FSM, the registers (PC, IR, BR, ACC, MAR, MBR) and the handshake live in acc_cpu_core.

## Test plan
- Basic program (defaults, zero-wait memory):
  - Stimulus: M[0]=0x0110, M[1]=0x0311, M[2]=0x0212, M[3]=0x0F00, M[0x10]=0x7FFF, M[0x11]=0x0001.
  - Response: M[0x12]=0x8000, flags={0,0,1,1}, halted rises exactly 13 cycles after rst falls.
- Same program with random 0–3 wait cycles per transaction:
  - Response: identical final state.
  - mem_addr, mem_we and mem_wdata do not change while req is high and ack is low.
- Conditional branches:
  - JGEZ with ACC=0xFFFF → not taken, PC=next.
  - JZ after SUB 5−5 → taken; ZF=1, CF=0.
  - JMP from address 0xFF → PC=target; sequential fetch from 0xFF wraps to 0x00.
- MPY and SUB boundaries:
  - MPY 0x0100×0x0100 → ACC=0x0000, CF=OF=1, ZF=1.
  - SUB 0x0000−0x0001 → ACC=0xFFFF, CF=1, SF=1.
- Illegal opcode 0x0E:
  - Response: illegal=1, halted=1; no further mem_req.
  - rst mid-OPERAND wait state (req high, no ack) → mem_req=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, FSM states, flag bit
// positions and a small decode helper.
package acc_cpu_pkg;

    // Decoded opcode values (low four bits of the opcode field)
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_MPY   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JGEZ  = 4'hC;
    localparam logic [3:0] OP_JZ    = 4'hD;
    localparam logic [3:0] OP_ILL   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Bit positions inside the 4-bit flags vector {ZF, CF, OF, SF}
    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPERAND,
        EXECUTE,
        WRITE,
        HALT
    } state_e;

    // States that own the memory bus and therefore drive a request
    function automatic logic is_bus_state(state_e s);
        return (s == FETCH) || (s == OPERAND) || (s == WRITE);
    endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Memory request/acknowledge bus between the CPU core (master) and the
// memory or arbiter (slave).
interface acc_cpu_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: computes the new accumulator value and the flags that
// the core latches in EXECUTE.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] br,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [2*DATA_W-1:0] prod;
    logic [SH_W-1:0]     sh;
    logic                cf;
    logic                of;

    // Result and carry/overflow selection for each ALU opcode
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        result = acc;
        cf     = 1'b0;
        of     = 1'b0;
        sum    = {1'b0, acc} + {1'b0, br};
        diff   = {1'b0, acc} - {1'b0, br};
        prod   = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, br};
        sh     = br[SH_W-1:0];
        case (op)
            OP_LOAD: result = br;
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                cf     = sum[DATA_W];
                of     = (acc[MSB] == br[MSB]) && (sum[MSB] != acc[MSB]);
            end
            OP_SUB: begin
                // Bit DATA_W of the zero-extended difference is the borrow
                result = diff[DATA_W-1:0];
                cf     = diff[DATA_W];
                of     = (acc[MSB] != br[MSB]) && (diff[MSB] != acc[MSB]);
            end
            OP_MPY: begin
                result = prod[DATA_W-1:0];
                cf     = |prod[2*DATA_W-1:DATA_W];
                of     = |prod[2*DATA_W-1:DATA_W];
            end
            OP_AND:  result = acc & br;
            OP_OR:   result = acc | br;
            OP_NOT:  result = ~br;
            OP_SHL:  result = acc << sh;
            OP_SHR:  result = acc >> sh;
            default: result = acc;
        endcase
        flags          = 4'b0000;
        flags[FLAG_ZF] = (result == '0);
        flags[FLAG_CF] = cf;
        flags[FLAG_OF] = of;
        flags[FLAG_SF] = result[MSB];
    end
endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: FETCH/DECODE/OPERAND/EXECUTE/WRITE/HALT
// sequencer, architectural registers and the memory handshake.
// DATA_W must be at least ADDR_W+4 so the opcode field holds four bits.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    acc_cpu_if.master         mem,
    output logic [DATA_W-1:0] acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        flags,
    output logic              halted,
    output logic              illegal
);
    localparam int                OPF_W   = DATA_W - ADDR_W;
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    state_e            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] br;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] mbr;
    logic [3:0]        flags_q;
    logic              illegal_q;

    logic [OPF_W-1:0]  op_field;
    logic [3:0]        opc;
    logic [ADDR_W-1:0] operand;
    logic              op_bad;
    logic              taken;
    logic [ADDR_W-1:0] next_pc;
    logic              xfer;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    // Instruction fields; any set bit above the decoded nibble is illegal
    assign op_field = ir[DATA_W-1:ADDR_W];
    assign opc      = op_field[3:0];
    assign operand  = ir[ADDR_W-1:0];
    assign op_bad   = ((op_field >> 4) != '0) || (opc == OP_ILL);

    // Branch resolution in DECODE; NOP and untaken jumps keep the fetched PC
    assign taken   = (opc == OP_JMP)
                   || ((opc == OP_JGEZ) && !acc[DATA_W-1])
                   || ((opc == OP_JZ) && flags_q[FLAG_ZF]);
    assign next_pc = taken ? operand : pc;

    // Request is gated by rst so it drops the instant reset asserts
    assign mem.mem_req   = !rst && is_bus_state(state);
    assign mem.mem_we    = (state == WRITE);
    assign mem.mem_addr  = mar;
    assign mem.mem_wdata = mbr;
    assign xfer          = mem.mem_req && mem.mem_ack;

    assign acc_out = acc;
    assign pc_out  = pc;
    assign flags   = flags_q;
    assign halted  = (state == HALT);
    assign illegal = illegal_q;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opc),
        .acc    (acc),
        .br     (br),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // Instruction sequencer and architectural register updates
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= PC_INIT;
            ir        <= '0;
            br        <= '0;
            acc       <= '0;
            mar       <= PC_INIT;
            mbr       <= '0;
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (xfer) begin
                        ir    <= mem.mem_rdata;
                        pc    <= pc + ADDR_W'(1);
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (op_bad) begin
                        illegal_q <= 1'b1;
                        state     <= HALT;
                    end else begin
                        case (opc)
                            OP_NOP, OP_JMP, OP_JGEZ, OP_JZ: begin
                                pc    <= next_pc;
                                mar   <= next_pc;
                                state <= FETCH;
                            end
                            OP_STORE: begin
                                mar   <= operand;
                                mbr   <= acc;
                                state <= WRITE;
                            end
                            OP_HALT: state <= HALT;
                            default: begin
                                mar   <= operand;
                                state <= OPERAND;
                            end
                        endcase
                    end
                end
                OPERAND: begin
                    if (xfer) begin
                        br    <= mem.mem_rdata;
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    acc     <= alu_result;
                    flags_q <= alu_flags;
                    mar     <= pc;
                    state   <= FETCH;
                end
                WRITE: begin
                    if (xfer) begin
                        mar   <= pc;
                        state <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core: behavioural memory with random wait
// states, a write scoreboard and directed programs.
module tb_acc_cpu_core;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] acc_out;
    logic [ADDR_W-1:0] pc_out;
    logic [3:0]        flags;
    logic              halted;
    logic              illegal;

    acc_cpu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

    acc_cpu_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .mem     (mem_if.master),
        .acc_out (acc_out),
        .pc_out  (pc_out),
        .flags   (flags),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural memory and write scoreboard
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        flags;
    } wr_t;

    logic [DATA_W-1:0] mem [256];
    wr_t               sb_q[$];
    int                max_wait = 0;
    bit                stall_en = 1'b0;
    logic [ADDR_W-1:0] stall_addr = '0;
    bit                in_txn = 1'b0;
    int                wait_left = 0;
    logic [ADDR_W-1:0] t_addr;
    logic              t_we;
    logic [DATA_W-1:0] t_wdata;

    // Memory responder: decides ack/rdata on the falling edge for the next rising edge
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            in_txn           = 1'b0;
            mem_if.mem_ack   = 1'b0;
            mem_if.mem_rdata = '0;
        end else if (mem_if.mem_req) begin
            if (!in_txn) begin
                in_txn    = 1'b1;
                wait_left = (max_wait > 0) ? int'($urandom_range(max_wait, 0)) : 0;
                t_addr    = mem_if.mem_addr;
                t_we      = mem_if.mem_we;
                t_wdata   = mem_if.mem_wdata;
            end else begin
                check("hold_addr", mem_if.mem_addr, t_addr);
                check("hold_we", mem_if.mem_we, t_we);
                if (t_we) check("hold_wdata", mem_if.mem_wdata, t_wdata);
            end
            if (stall_en && mem_if.mem_addr == stall_addr) begin
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = 16'hDEAD;
            end else if (wait_left > 0) begin
                wait_left--;
                mem_if.mem_ack   = 1'b0;
                mem_if.mem_rdata = 16'hDEAD;
            end else begin
                mem_if.mem_ack = 1'b1;
                in_txn         = 1'b0;
                if (mem_if.mem_we) begin
                    check("sb_pending", sb_q.size() != 0, 1'b1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("wr_addr", mem_if.mem_addr, e.addr);
                        check("wr_data", mem_if.mem_wdata, e.data);
                        check("wr_flags", flags, e.flags);
                    end
                    mem[mem_if.mem_addr] = mem_if.mem_wdata;
                end else begin
                    mem_if.mem_rdata = mem[mem_if.mem_addr];
                end
            end
        end else begin
            mem_if.mem_ack = 1'b0;
        end
    end

    task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [3:0] f);
        wr_t e;
        e.addr  = a;
        e.data  = d;
        e.flags = f;
        sb_q.push_back(e);
    endtask

    // Assert reset (called at posedge+1) and prepare an empty memory
    task automatic start_test(input int mw);
        rst      = 1'b1;
        stall_en = 1'b0;
        max_wait = mw;
        sb_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_until_halt(input int budget, output int cyc);
        cyc = 0;
        while (!halted && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, ".req"}, mem_if.mem_req, 1'b0);
        check({pfx, ".we"}, mem_if.mem_we, 1'b0);
        check({pfx, ".addr"}, mem_if.mem_addr, 8'h00);
        check({pfx, ".wdata"}, mem_if.mem_wdata, 16'h0000);
        check({pfx, ".acc"}, acc_out, 16'h0000);
        check({pfx, ".pc"}, pc_out, 8'h00);
        check({pfx, ".flags"}, flags, 4'b0000);
        check({pfx, ".halted"}, halted, 1'b0);
        check({pfx, ".illegal"}, illegal, 1'b0);
    endtask

    task automatic check_state(input string pfx, input logic [DATA_W-1:0] e_acc,
                               input logic [ADDR_W-1:0] e_pc, input logic [3:0] e_fl,
                               input logic e_ill);
        check({pfx, ".acc"}, acc_out, e_acc);
        check({pfx, ".pc"}, pc_out, e_pc);
        check({pfx, ".flags"}, flags, e_fl);
        check({pfx, ".illegal"}, illegal, e_ill);
        check({pfx, ".sb_drained"}, sb_q.size(), 0);
    endtask

    task automatic check_quiet(input string pfx);
        int reqs;
        reqs = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (mem_if.mem_req) reqs++;
        end
        check({pfx, ".no_req"}, reqs, 0);
        check({pfx, ".halted"}, halted, 1'b1);
    endtask

    task automatic load_basic();
        mem[8'h00] = 16'h0110;
        mem[8'h01] = 16'h0311;
        mem[8'h02] = 16'h0212;
        mem[8'h03] = 16'h0F00;
        mem[8'h10] = 16'h7FFF;
        mem[8'h11] = 16'h0001;
        push_wr(8'h12, 16'h8000, 4'b0011);
    endtask

    initial begin
        int cyc;

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");

        // Basic program, zero-wait memory
        start_test(0);
        load_basic();
        release_reset();
        #1;
        check("first_req", mem_if.mem_req, 1'b1);
        check("first_addr", mem_if.mem_addr, 8'h00);
        check("first_we", mem_if.mem_we, 1'b0);
        run_until_halt(200, cyc);
        check("halt_latency", cyc, 13);
        check_state("basic", 16'h8000, 8'h04, 4'b0011, 1'b0);
        check("basic.m12", mem[8'h12], 16'h8000);
        check_quiet("basic");

        // Same program with 0-3 wait cycles per transaction
        start_test(3);
        load_basic();
        release_reset();
        run_until_halt(500, cyc);
        check_state("waits", 16'h8000, 8'h04, 4'b0011, 1'b0);
        check("waits.m12", mem[8'h12], 16'h8000);

        // Branches, PC wrap, MPY and SUB boundaries
        start_test(1);
        mem[8'h00] = 16'h0D50;  // JZ 0x50 (not taken first pass, taken after wrap)
        mem[8'h01] = 16'h0120;  // LOAD 0x20 -> 0xFFFF
        mem[8'h02] = 16'h0C30;  // JGEZ 0x30 (not taken)
        mem[8'h03] = 16'h0121;  // LOAD 0x21 -> 5
        mem[8'h04] = 16'h0421;  // SUB 0x21 -> 0
        mem[8'h05] = 16'h0222;  // STORE 0x22
        mem[8'h06] = 16'h0D40;  // JZ 0x40 (taken)
        mem[8'h07] = 16'h0F00;  // wrong path
        mem[8'h30] = 16'h0F00;  // wrong path
        mem[8'h40] = 16'h0BFF;  // JMP 0xFF
        mem[8'hFF] = 16'h0224;  // STORE 0x24, then fetch wraps to 0x00
        mem[8'h50] = 16'h0123;  // LOAD 0x23 -> 0x0100
        mem[8'h51] = 16'h0523;  // MPY 0x23 -> 0x0000, CF=OF=1
        mem[8'h52] = 16'h0225;  // STORE 0x25
        mem[8'h53] = 16'h0126;  // LOAD 0x26 -> 0
        mem[8'h54] = 16'h0427;  // SUB 0x27 -> 0xFFFF
        mem[8'h55] = 16'h0F00;  // HALT
        mem[8'h20] = 16'hFFFF;
        mem[8'h21] = 16'h0005;
        mem[8'h23] = 16'h0100;
        mem[8'h26] = 16'h0000;
        mem[8'h27] = 16'h0001;
        push_wr(8'h22, 16'h0000, 4'b1000);
        push_wr(8'h24, 16'h0000, 4'b1000);
        push_wr(8'h25, 16'h0000, 4'b1110);
        release_reset();
        run_until_halt(1000, cyc);
        check_state("branch", 16'hFFFF, 8'h56, 4'b0101, 1'b0);

        // Illegal opcode 0xE
        start_test(0);
        mem[8'h00] = 16'h0110;
        mem[8'h01] = 16'h0E00;
        mem[8'h10] = 16'h1234;
        release_reset();
        run_until_halt(200, cyc);
        check_state("ill_e", 16'h1234, 8'h02, 4'b0000, 1'b1);
        check_quiet("ill_e");

        // Nonzero upper opcode bits are illegal even with a valid low nibble
        start_test(0);
        mem[8'h00] = 16'h1F00;
        release_reset();
        run_until_halt(200, cyc);
        check_state("ill_hi", 16'h0000, 8'h01, 4'b0000, 1'b1);

        // Reset during an OPERAND wait state
        start_test(0);
        mem[8'h00] = 16'h0110;
        mem[8'h10] = 16'h1234;
        stall_en   = 1'b1;
        stall_addr = 8'h10;
        release_reset();
        cyc = 0;
        while (!(mem_if.mem_req && mem_if.mem_addr == 8'h10) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stall_reached", mem_if.mem_req && mem_if.mem_addr == 8'h10, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("stall_req_held", mem_if.mem_req, 1'b1);
        check("stall_pc", pc_out, 8'h01);
        rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        stall_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
